scalar_add_driver: RTL and testbench

Request-side counterpart of the scalar add unit. It generates a deterministic sequence of operand pairs, issues them over a valid/ready request channel, and consumes sums over a valid/ready response channel. Each sum is checked against an internally computed expected value, and pass/error statistics are reported. It sits in the Verilator scalar-add app as the on-chip traffic generator and checker facing the adder under test.

---
 rtl/scalar_add_driver.sv | 180 ++++++++++++++++++
 tb/tb_scalar_add_driver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_add_driver.sv
// rtl/scalar_add_driver.sv - operand generator and sum checker facing a scalar adder
module scalar_add_driver #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          NUM_OPS    = 16,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0]    A_BASE     = DATA_W'(0),
  parameter logic [DATA_W-1:0]    A_STEP     = DATA_W'(3),
  parameter logic [DATA_W-1:0]    B_BASE     = DATA_W'(1),
  parameter logic [DATA_W-1:0]    B_STEP     = DATA_W'(5)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [DATA_W-1:0] req_a,
  output logic [DATA_W-1:0] req_b,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [DATA_W-1:0] resp_y,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       err_cnt,
  output logic              first_err_valid,
  output logic [15:0]       first_err_idx
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [15:0] LAST_IDX = 16'(NUM_OPS - 1);
  localparam logic [15:0] SAT      = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Expected-sum FIFO: one entry per issued request, popped per checked response
  logic [DATA_W-1:0] exp_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic [15:0] issue_idx_q;
  logic [15:0] resp_idx_q;

  logic fifo_full, fifo_empty;
  logic req_fire, resp_fire;
  logic clear;
  logic match;

  // Fullness uses the registered count, so a same-cycle pop never frees a slot
  // for a push; this also keeps a pending request stable until it is taken.
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign req_valid  = (state_q == RUN) && !fifo_full;
  assign resp_ready = ((state_q == RUN) || (state_q == DRAIN)) && !fifo_empty;

  assign req_fire   = req_valid && req_ready;
  assign resp_fire  = resp_valid && resp_ready;
  assign match      = (resp_y == exp_mem[rd_ptr_q]);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, status flags and the run-clear strobe
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (req_fire && (issue_idx_q == LAST_IDX)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (resp_fire && (resp_idx_q == LAST_IDX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Expected sums are stored at request acceptance; storage needs no reset
  always_ff @(posedge clock) begin
    if (req_fire) begin
      exp_mem[wr_ptr_q] <= req_a + req_b;
    end
  end

  // Operand accumulators, FIFO bookkeeping, indices and statistics
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_a           <= '0;
      req_b           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      issue_idx_q     <= '0;
      resp_idx_q      <= '0;
      pass_cnt        <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (clear) begin
      req_a           <= A_BASE;
      req_b           <= B_BASE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      issue_idx_q     <= '0;
      resp_idx_q      <= '0;
      pass_cnt        <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      if (req_fire) begin
        req_a       <= req_a + A_STEP;
        req_b       <= req_b + B_STEP;
        wr_ptr_q    <= wr_ptr_q + PTR_W'(1);
        issue_idx_q <= issue_idx_q + 16'd1;
      end
      if (resp_fire) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        resp_idx_q <= resp_idx_q + 16'd1;
        if (match) begin
          if (pass_cnt != SAT) begin
            pass_cnt <= pass_cnt + 16'd1;
          end
        end else begin
          if (err_cnt != SAT) begin
            err_cnt <= err_cnt + 16'd1;
          end
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= resp_idx_q;
          end
        end
      end
      case ({req_fire, resp_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_add_driver.sv
// tb/tb_scalar_add_driver.sv - randomized self-checking bench for scalar_add_driver
module tb_scalar_add_driver;

  localparam int N = 16;
  localparam int D = 4;
  localparam logic [31:0] A0  = 32'h0;
  localparam logic [31:0] AS  = 32'd3;
  localparam logic [31:0] B0  = 32'd1;
  localparam logic [31:0] BS  = 32'd5;
  localparam logic [31:0] WA0 = 32'hFFFF_FFF0;
  localparam logic [31:0] WB0 = 32'h0000_0020;

  localparam int M_PLAIN = 0;
  localparam int M_HOLD  = 1;
  localparam int M_STALL = 2;
  localparam int M_START = 3;
  localparam int M_RESET = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, req_valid, resp_ready;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] req_a, req_b;
  logic [31:0] resp_y = 32'd0;
  logic [15:0] pass_cnt, err_cnt, first_err_idx;
  logic        first_err_valid;

  logic        start_w = 1'b0;
  logic        busy_w, done_w, req_valid_w, resp_ready_w;
  logic        req_ready_w = 1'b1;
  logic        resp_valid_w = 1'b0;
  logic [31:0] req_a_w, req_b_w;
  logic [31:0] resp_y_w = 32'd0;
  logic [15:0] pass_cnt_w, err_cnt_w, first_err_idx_w;
  logic        first_err_valid_w;

  scalar_add_driver u_dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
  );

  scalar_add_driver #(.A_BASE(WA0), .B_BASE(WB0)) u_wrap (
    .clock(clock), .reset(reset), .start(start_w), .busy(busy_w), .done(done_w),
    .req_valid(req_valid_w), .req_ready(req_ready_w), .req_a(req_a_w), .req_b(req_b_w),
    .resp_valid(resp_valid_w), .resp_ready(resp_ready_w), .resp_y(resp_y_w),
    .pass_cnt(pass_cnt_w), .err_cnt(err_cnt_w),
    .first_err_valid(first_err_valid_w), .first_err_idx(first_err_idx_w)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Adder model state: pending sums, handshake counts, and stimulus knobs
  logic [31:0] rq[$];
  int          n_req = 0;
  int          n_resp = 0;
  bit          live = 1'b0;
  bit          req_hold = 1'b0;
  bit          resp_hold = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          resp_rand = 1'b0;
  logic [15:0] inj = 16'h0;

  // Drive the adder side on the falling edge; record handshakes for the next rising edge
  always @(negedge clock) begin
    logic [31:0] sum;
    req_ready  = !req_hold && (!rdy_rand || ($urandom_range(0, 3) != 0));
    resp_valid = (rq.size() > 0) && !resp_hold && (!resp_rand || ($urandom_range(0, 2) != 0));
    if (resp_valid) resp_y = rq[0] ^ {31'd0, (n_resp < N) && inj[n_resp[3:0]]};
    else            resp_y = $urandom;
    if (reset) begin
      expect_eq("resp_ready", 32'(resp_ready), 32'(live && (n_req != n_resp)));
      if (req_valid && req_ready) begin
        expect_eq("req_a", req_a, A0 + AS * n_req);
        expect_eq("req_b", req_b, B0 + BS * n_req);
        expect_eq("outstanding_lt_depth", 32'((n_req - n_resp) < D), 32'd1);
        expect_eq("req_within_run", 32'(n_req < N), 32'd1);
        sum = req_a + req_b;
        rq.push_back(sum);
        n_req++;
      end
      if (resp_valid && resp_ready) begin
        void'(rq.pop_front());
        n_resp++;
      end
    end
  end

  // Ideal adder for the wrap-around instance
  logic [31:0] wq[$];
  int          wn = 0;

  always @(negedge clock) begin
    resp_valid_w = (wq.size() > 0);
    resp_y_w     = resp_valid_w ? wq[0] : 32'd0;
    if (reset) begin
      if (req_valid_w && req_ready_w) begin
        expect_eq("wrap_a", req_a_w, WA0 + AS * wn);
        expect_eq("wrap_b", req_b_w, WB0 + BS * wn);
        if (wn == 0) expect_eq("wrap_exp0", req_a_w + req_b_w, 32'h0000_0010);
        wq.push_back(req_a_w + req_b_w);
        wn++;
      end
      if (resp_valid_w && resp_ready_w) void'(wq.pop_front());
    end
  end

  task automatic hold_check();
    logic [31:0] ea, eb;
    req_hold = 1'b1;
    repeat (2) @(negedge clock);
    ea = A0 + AS * n_req;
    eb = B0 + BS * n_req;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      expect_eq("hold_valid", 32'(req_valid), 32'd1);
      expect_eq("hold_a", req_a, ea);
      expect_eq("hold_b", req_b, eb);
    end
    req_hold = 1'b0;
  endtask

  task automatic stall_check();
    resp_hold = 1'b1;
    repeat (8) @(negedge clock);
    expect_eq("stall_valid", 32'(req_valid), 32'd0);
    expect_eq("stall_outstanding", 32'(n_req - n_resp), 32'(D));
    resp_hold = 1'b0;
  endtask

  task automatic reset_check();
    @(posedge clock);
    #2;
    reset = 1'b0;
    live  = 1'b0;
    #1;
    expect_eq("rst_busy", 32'(busy), 32'd0);
    expect_eq("rst_done", 32'(done), 32'd0);
    expect_eq("rst_req_valid", 32'(req_valid), 32'd0);
    expect_eq("rst_req_a", req_a, 32'd0);
    expect_eq("rst_req_b", req_b, 32'd0);
    expect_eq("rst_resp_ready", 32'(resp_ready), 32'd0);
    expect_eq("rst_pass", 32'(pass_cnt), 32'd0);
    expect_eq("rst_err", 32'(err_cnt), 32'd0);
    expect_eq("rst_fev", 32'(first_err_valid), 32'd0);
    expect_eq("rst_fei", 32'(first_err_idx), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      expect_eq("post_rst_resp_ready", 32'(resp_ready), 32'd0);
      expect_eq("post_rst_busy", 32'(busy), 32'd0);
    end
    rq.delete();
  endtask

  task automatic do_run(input logic [15:0] mask, input bit rr, input bit sr, input int mode);
    bit          acted;
    bit          fin;
    int          exp_err;
    logic [15:0] exp_idx;
    acted     = 1'b0;
    fin       = 1'b0;
    inj       = mask;
    rdy_rand  = rr;
    resp_rand = sr;
    exp_err   = $countones(mask);
    exp_idx   = 16'd0;
    for (int i = N - 1; i >= 0; i--) if (mask[i]) exp_idx = 16'(i);
    @(negedge clock);
    n_req  = 0;
    n_resp = 0;
    rq.delete();
    live  = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    expect_eq("start_busy", 32'(busy), 32'd1);
    expect_eq("start_done", 32'(done), 32'd0);
    expect_eq("start_req_valid", 32'(req_valid), 32'd1);
    expect_eq("start_req_a", req_a, A0);
    expect_eq("start_req_b", req_b, B0);
    expect_eq("start_pass_clr", 32'(pass_cnt), 32'd0);
    expect_eq("start_err_clr", 32'(err_cnt), 32'd0);
    expect_eq("start_fev_clr", 32'(first_err_valid), 32'd0);
    for (int c = 0; c < 4000 && !done && !fin; c++) begin
      @(negedge clock);
      if (!acted && (n_req >= ((mode == M_RESET) ? 7 : 5))) begin
        acted = 1'b1;
        case (mode)
          M_HOLD:  hold_check();
          M_STALL: stall_check();
          M_START: begin start = 1'b1; @(negedge clock); start = 1'b0; end
          M_RESET: begin reset_check(); fin = 1'b1; end
          default: ;
        endcase
      end
    end
    if (fin) return;
    expect_eq("run_done", 32'(done), 32'd1);
    expect_eq("run_busy", 32'(busy), 32'd0);
    expect_eq("run_n_req", 32'(n_req), 32'(N));
    expect_eq("run_n_resp", 32'(n_resp), 32'(N));
    expect_eq("run_pass", 32'(pass_cnt), 32'(N - exp_err));
    expect_eq("run_err", 32'(err_cnt), 32'(exp_err));
    expect_eq("run_fev", 32'(first_err_valid), 32'(exp_err != 0));
    expect_eq("run_fei", 32'(first_err_idx), 32'(exp_idx));
  endtask

  initial begin
    #2;
    expect_eq("init_busy", 32'(busy), 32'd0);
    expect_eq("init_done", 32'(done), 32'd0);
    expect_eq("init_req_valid", 32'(req_valid), 32'd0);
    expect_eq("init_req_a", req_a, 32'd0);
    expect_eq("init_resp_ready", 32'(resp_ready), 32'd0);
    expect_eq("init_pass", 32'(pass_cnt), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    do_run(16'h0000, 1'b0, 1'b0, M_PLAIN);
    do_run(16'h0000, 1'b0, 1'b0, M_HOLD);
    do_run(16'h0000, 1'b0, 1'b0, M_STALL);
    do_run(16'h0220, 1'b0, 1'b0, M_PLAIN);
    do_run(16'h0000, 1'b0, 1'b0, M_START);
    do_run(16'h0000, 1'b0, 1'b0, M_RESET);
    do_run(16'h0000, 1'b0, 1'b0, M_PLAIN);
    for (int r = 0; r < 4; r++) begin
      do_run(16'($urandom), 1'b1, 1'b1, M_PLAIN);
    end
    do_run(16'h0000, 1'b1, 1'b1, M_PLAIN);

    @(negedge clock);
    wn = 0;
    wq.delete();
    start_w = 1'b1;
    @(negedge clock);
    start_w = 1'b0;
    for (int c = 0; c < 500 && !done_w; c++) @(negedge clock);
    expect_eq("wrap_done", 32'(done_w), 32'd1);
    expect_eq("wrap_busy", 32'(busy_w), 32'd0);
    expect_eq("wrap_n", 32'(wn), 32'(N));
    expect_eq("wrap_pass", 32'(pass_cnt_w), 32'(N));
    expect_eq("wrap_err", 32'(err_cnt_w), 32'd0);
    expect_eq("wrap_fev", 32'(first_err_valid_w), 32'd0);
    expect_eq("wrap_fei", 32'(first_err_idx_w), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
